activation_unit: RTL and testbench
==================================

ACTIVATION_UNIT -- requirements
Module: activation_unit

Interface
REQ-001 SHALL have parameter Q_INT, 8, integer bits of the signed data format.
REQ-002 SHALL have parameter Q_FRAC, 8, fraction bits; Q_SIZE = Q_INT+Q_FRAC.
REQ-003 SHALL have parameter LANES, 2, parallel data lanes per beat.
REQ-004 SHALL have parameter LUT_DEPTH, 4, segment-address bits (2^LUT_DEPTH segments per slot).
REQ-005 SHALL have parameter SLOT_BITS, 2, function-slot select bits.
REQ-006 SHALL have parameters A_Q_INT/A_Q_FRAC, 4/12, and B_Q_INT/B_Q_FRAC, 8/8, slope and offset formats.
REQ-007 SHALL have parameter LEAK_SHIFT, 3, arithmetic right shift for leaky ReLU.
REQ-008 SHALL have port clk  in  1  sole clock, rising edge.
REQ-009 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-010 SHALL have ports in_valid in 1, in_ready out 1, in_x in LANES*Q_SIZE (lane 0 in LSBs), in_mode in 3, in_slot in SLOT_BITS.
REQ-011 SHALL have ports out_valid out 1, out_ready in 1, out_fx out LANES*Q_SIZE, out_sat out LANES (per-lane saturation flag).
REQ-012 SHALL have ports cfg_we in 1, cfg_slot in SLOT_BITS, cfg_addr in LUT_DEPTH, cfg_data in (A width + B width, slope in MSBs), cfg_clr in 1.
REQ-013 SHALL have port sat_count out 16, count of output beats with any out_sat bit set.

Function
REQ-014 A beat SHALL transfer on input when in_valid&in_ready, on output when out_valid&out_ready.
REQ-015 Pipeline SHALL have 3 stages (S1 LUT read/register x, S2 multiply, S3 add/saturate/mode mux); accepted beat appears on out_valid exactly 3 cycles later absent stall.
REQ-016 Global advance en = ~out_valid | out_ready; in_ready SHALL equal en (combinational); all stages and LUT read registers SHALL hold when en=0.
REQ-017 Each stage SHALL carry a valid bit; bubbles SHALL propagate; beats SHALL never be dropped, duplicated, or reordered.
REQ-018 LUT SHALL hold 2^(SLOT_BITS+LUT_DEPTH) entries, replicated per lane with broadcast writes; read address = {in_slot, x[Q_INT-1 -: LUT_DEPTH]} (sign-inclusive top bits, unsigned index).
REQ-019 cfg_we SHALL write on any cycle regardless of stall; same-cycle read of the written address SHALL return old data.
REQ-020 Mode 0 LUT: fx = a*x + b, b aligned to the product's binary point, product fraction truncated to Q_FRAC (floor), then saturated.
REQ-021 Mode 1 ID: fx = x. Mode 2 STEP: fx = 1.0 (1<<Q_FRAC) if x>=0 else 0. Mode 3 RELU: fx = x if x>=0 else 0.
REQ-022 Mode 4 LEAKY: fx = x if x>=0 else x>>>LEAK_SHIFT. Modes 5-7 reserved: fx = 0, out_sat = 0.
REQ-023 Saturation SHALL clamp to [-2^(Q_SIZE-1), 2^(Q_SIZE-1)-1] raw, setting that lane's out_sat; only mode 0 can saturate.
REQ-024 sat_count SHALL increment on each output transfer with |out_sat, stick at 0xFFFF, and clear on cfg_clr (clear wins over simultaneous increment).
REQ-025 out_fx/out_sat SHALL be registered and held stable while out_valid&~out_ready.

Reset
REQ-026 rst_n low SHALL immediately clear all stage valid bits, out_valid, out_fx, out_sat, sat_count to 0; in_ready reads 1 while in reset.
REQ-027 Reset mid-operation SHALL discard in-flight beats; LUT contents SHALL NOT be cleared by reset.
REQ-028 Reset deassertion SHALL be synchronised to clk; first transfer allowed on the first rising edge after synchronised release.

Verification (Q8.8, LANES=2, LUT_DEPTH=4, A Q4.12, B Q8.8, LEAK_SHIFT=3)
REQ-029 Mode 3, x={0xFF00, 0x0180}, out_ready=1 -> 3 cycles later out_fx={0x0000, 0x0180}, out_sat=0.
REQ-030 Slot 0 addr 0 written a=0x2000, b=0x0100; mode 0, x=0x0200 -> fx=0x0500, out_sat=0; mode 4, x=0xFF00 -> fx=0xFFE0.
REQ-031 a=0x7FFF, b=0x0000, mode 0, x=0x7F00 -> fx=0x7FFF, out_sat=1, sat_count 0->1; cfg_clr same cycle as next saturated transfer -> sat_count=0.
REQ-032 out_ready low 6 cycles, in_valid high with 5 distinct beats -> exactly 3 accepted, in_ready low after, all 5 emitted in order once out_ready high, none lost/duplicated.
REQ-033 cfg_we to slot 1 addr 2 same cycle a beat reads it -> that beat uses old coefficients, next beat uses new.
REQ-034 rst_n pulsed low with 3 beats in flight -> out_valid=0 and sat_count=0 asynchronously, no stale beat emitted after release, LUT coefficients preserved.

Source files
------------

// File: rtl/activation_unit_if.sv
// Streaming, configuration and status signals of activation_unit.
// The master side drives beats and configuration; the slave side is the unit.
interface activation_unit_if #(
    parameter int unsigned Q_SIZE    = 16,
    parameter int unsigned LANES     = 2,
    parameter int unsigned SLOT_BITS = 2,
    parameter int unsigned LUT_DEPTH = 4,
    parameter int unsigned CFG_W     = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*Q_SIZE-1:0]   in_x;
    logic [2:0]                in_mode;
    logic [SLOT_BITS-1:0]      in_slot;

    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*Q_SIZE-1:0]   out_fx;
    logic [LANES-1:0]          out_sat;

    logic                      cfg_we;
    logic [SLOT_BITS-1:0]      cfg_slot;
    logic [LUT_DEPTH-1:0]      cfg_addr;
    logic [CFG_W-1:0]          cfg_data;
    logic                      cfg_clr;
    logic [15:0]               sat_count;

    modport master (
        output in_valid, in_x, in_mode, in_slot, out_ready,
        output cfg_we, cfg_slot, cfg_addr, cfg_data, cfg_clr,
        input  in_ready, out_valid, out_fx, out_sat, sat_count
    );

    modport slave (
        input  in_valid, in_x, in_mode, in_slot, out_ready,
        input  cfg_we, cfg_slot, cfg_addr, cfg_data, cfg_clr,
        output in_ready, out_valid, out_fx, out_sat, sat_count
    );
endinterface

// File: rtl/activation_unit.sv
// Three-stage streaming activation unit: per-slot piecewise-linear LUT (a*x+b) or
// fixed identity/step/ReLU/leaky-ReLU on LANES signed fixed-point lanes per beat.
module activation_unit #(
    parameter int unsigned Q_INT      = 8,
    parameter int unsigned Q_FRAC     = 8,
    parameter int unsigned LANES      = 2,
    parameter int unsigned LUT_DEPTH  = 4,
    parameter int unsigned SLOT_BITS  = 2,
    parameter int unsigned A_Q_INT    = 4,
    parameter int unsigned A_Q_FRAC   = 12,
    parameter int unsigned B_Q_INT    = 8,
    parameter int unsigned B_Q_FRAC   = 8,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    activation_unit_if.slave bus
);
    localparam int unsigned Q_SIZE  = Q_INT + Q_FRAC;
    localparam int unsigned A_W     = A_Q_INT + A_Q_FRAC;
    localparam int unsigned B_W     = B_Q_INT + B_Q_FRAC;
    localparam int unsigned CFG_W   = A_W + B_W;
    localparam int unsigned ADDR_W  = SLOT_BITS + LUT_DEPTH;
    localparam int unsigned ENTRIES = 1 << ADDR_W;
    localparam int unsigned X_W     = LANES * Q_SIZE;
    localparam int unsigned PROD_W  = A_W + Q_SIZE;
    localparam int unsigned SUM_W   = PROD_W + 1;
    localparam int unsigned B_SHIFT = A_Q_FRAC + Q_FRAC - B_Q_FRAC;

    localparam logic [Q_SIZE-1:0] FX_MAX = {1'b0, {(Q_SIZE-1){1'b1}}};
    localparam logic [Q_SIZE-1:0] FX_MIN = {1'b1, {(Q_SIZE-1){1'b0}}};
    localparam logic [Q_SIZE-1:0] FX_ONE = Q_SIZE'(1) << Q_FRAC;

    // Reset release is synchronised; run goes high two edges after rst_n rises.
    logic [1:0] rst_sync;
    logic       run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    logic             en;
    logic             v1, v2, out_valid_q;
    logic [X_W-1:0]   out_fx_q;
    logic [LANES-1:0] out_sat_q;
    logic [15:0]      sat_cnt_q;

    assign en            = ~out_valid_q | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_fx    = out_fx_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.sat_count = sat_cnt_q;

    // Coefficient store, one copy per lane so every lane reads in parallel.
    logic [CFG_W-1:0]  lut     [LANES][ENTRIES];
    logic [ADDR_W-1:0] rd_addr [LANES];

    always_ff @(posedge clk) begin
        if (bus.cfg_we) begin
            for (int l = 0; l < int'(LANES); l++) begin
                lut[l][{bus.cfg_slot, bus.cfg_addr}] <= bus.cfg_data;
            end
        end
    end

    // Segment index is the top LUT_DEPTH bits of x, sign bit included, read as unsigned.
    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            rd_addr[l] = {bus.in_slot, bus.in_x[l*Q_SIZE + Q_SIZE - 1 -: LUT_DEPTH]};
        end
    end

    logic [2:0]               mode1, mode2;
    logic [X_W-1:0]           x1, x2;
    logic [CFG_W-1:0]         coef1 [LANES];
    logic signed [PROD_W-1:0] prod2 [LANES];
    logic signed [B_W-1:0]    b2    [LANES];

    // Datapath registers: S1 captures x and the LUT word, S2 forms the product.
    always_ff @(posedge clk) begin
        if (en) begin
            mode1 <= bus.in_mode;
            x1    <= bus.in_x;
            mode2 <= mode1;
            x2    <= x1;
            for (int l = 0; l < int'(LANES); l++) begin
                coef1[l] <= lut[l][rd_addr[l]];
                prod2[l] <= PROD_W'($signed(coef1[l][CFG_W-1 -: A_W]))
                          * PROD_W'($signed(x1[l*Q_SIZE +: Q_SIZE]));
                b2[l]    <= $signed(coef1[l][B_W-1:0]);
            end
        end
    end

    logic [X_W-1:0]   fx_c;
    logic [LANES-1:0] sat_c;

    // S3: align b to the product point, floor to Q_FRAC, saturate, then mode select.
    always_comb begin
        logic signed [Q_SIZE-1:0] xv;
        logic signed [SUM_W-1:0]  sum;
        logic signed [SUM_W-1:0]  res;
        logic                     ovf;
        logic [Q_SIZE-1:0]        lut_fx;
        fx_c   = '0;
        sat_c  = '0;
        xv     = '0;
        sum    = '0;
        res    = '0;
        ovf    = 1'b0;
        lut_fx = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            xv     = $signed(x2[l*Q_SIZE +: Q_SIZE]);
            sum    = SUM_W'(prod2[l]) + (SUM_W'(b2[l]) <<< B_SHIFT);
            res    = sum >>> A_Q_FRAC;
            ovf    = (res[SUM_W-1:Q_SIZE-1] != '0) && (res[SUM_W-1:Q_SIZE-1] != '1);
            lut_fx = ovf ? (res[SUM_W-1] ? FX_MIN : FX_MAX) : res[Q_SIZE-1:0];
            case (mode2)
                3'd0: begin
                    fx_c[l*Q_SIZE +: Q_SIZE] = lut_fx;
                    sat_c[l]                 = ovf;
                end
                3'd1: fx_c[l*Q_SIZE +: Q_SIZE] = xv;
                3'd2: fx_c[l*Q_SIZE +: Q_SIZE] = xv[Q_SIZE-1] ? '0 : FX_ONE;
                3'd3: fx_c[l*Q_SIZE +: Q_SIZE] = xv[Q_SIZE-1] ? '0 : xv;
                3'd4: begin
                    if (xv[Q_SIZE-1]) fx_c[l*Q_SIZE +: Q_SIZE] = xv >>> LEAK_SHIFT;
                    else              fx_c[l*Q_SIZE +: Q_SIZE] = xv;
                end
                default: ;
            endcase
        end
    end

    // Stage valids and the output register; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid_q <= 1'b0;
            out_fx_q    <= '0;
            out_sat_q   <= '0;
        end else if (!run) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid_q <= 1'b0;
            out_fx_q    <= '0;
            out_sat_q   <= '0;
        end else if (en) begin
            v1          <= bus.in_valid;
            v2          <= v1;
            out_valid_q <= v2;
            out_fx_q    <= fx_c;
            out_sat_q   <= sat_c;
        end
    end

    // Saturated-beat counter: sticky at all-ones, clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (!run || bus.cfg_clr) begin
            sat_cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready && (|out_sat_q) && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_activation_unit.sv
// Bench for activation_unit: vector table through a scoreboard, plus sequences for
// latency, stall, same-cycle LUT write, saturation counter clear and mid-flight reset.
module tb_activation_unit;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    activation_unit_if bus ();

    activation_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] x0;
        logic [15:0] x1;
        logic [2:0]  mode;
        logic [1:0]  slot;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [1:0]  sat;
    } vec_t;

    typedef struct {
        logic [31:0] fx;
        logic [1:0]  sat;
    } exp_t;

    exp_t        sb [$];
    exp_t        cur_exp;
    vec_t        tbl [13];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] sat_model = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output side: compare against scoreboard head every cycle the output is valid.
    always @(negedge clk) begin
        if (rst_n) begin
            logic inc;
            inc = 1'b0;
            check("sat_count", 32'(bus.sat_count), 32'(sat_model));
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected no output", bus.out_fx);
                end else begin
                    check("out_fx", bus.out_fx, sb[0].fx);
                    check("out_sat", 32'(bus.out_sat), 32'(sb[0].sat));
                    if (bus.out_ready) begin
                        inc = |sb[0].sat;
                        void'(sb.pop_front());
                    end
                end
            end
            if (bus.cfg_clr)                          sat_model = 16'd0;
            else if (inc && sat_model != 16'hFFFF)    sat_model = sat_model + 16'd1;
            if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_beat(input vec_t v);
        bus.in_valid   = 1'b1;
        bus.in_x       = {v.x1, v.x0};
        bus.in_mode    = v.mode;
        bus.in_slot    = v.slot;
        cur_exp.fx     = {v.e1, v.e0};
        cur_exp.sat    = v.sat;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input vec_t v);
        logic acc;
        acc = 1'b0;
        set_beat(v);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic cfg_wr(input logic [1:0] slot, input logic [3:0] addr,
                          input logic [15:0] a, input logic [15:0] b);
        bus.cfg_we   = 1'b1;
        bus.cfg_slot = slot;
        bus.cfg_addr = addr;
        bus.cfg_data = {a, b};
        tick(1);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic vec_t id_vec(input int k);
        vec_t v;
        v.x0   = 16'(16'h1100 * (k + 1));
        v.x1   = 16'(16'h0A00 + k);
        v.mode = 3'd1;
        v.slot = 2'd0;
        v.e0   = v.x0;
        v.e1   = v.x1;
        v.sat  = 2'b00;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   k;
        logic acc;
        vec_t v;

        //          x0        x1        mode  slot  e0        e1        sat
        tbl[0]  = '{16'hFF00, 16'h0180, 3'd3, 2'd0, 16'h0000, 16'h0180, 2'b00};
        tbl[1]  = '{16'h8000, 16'h7FFF, 3'd1, 2'd0, 16'h8000, 16'h7FFF, 2'b00};
        tbl[2]  = '{16'h0000, 16'hFFFF, 3'd2, 2'd0, 16'h0100, 16'h0000, 2'b00};
        tbl[3]  = '{16'h8000, 16'h0001, 3'd2, 2'd0, 16'h0000, 16'h0100, 2'b00};
        tbl[4]  = '{16'hFF00, 16'h0040, 3'd4, 2'd0, 16'hFFE0, 16'h0040, 2'b00};
        tbl[5]  = '{16'h8000, 16'hFFF9, 3'd4, 2'd0, 16'hF000, 16'hFFFF, 2'b00};
        tbl[6]  = '{16'h0200, 16'h0001, 3'd0, 2'd0, 16'h0500, 16'h0102, 2'b00};
        tbl[7]  = '{16'hFFFF, 16'hF001, 3'd0, 2'd0, 16'hFFFF, 16'hF800, 2'b00};
        tbl[8]  = '{16'h7F00, 16'h7F00, 3'd0, 2'd2, 16'h7FFF, 16'h7FFF, 2'b11};
        tbl[9]  = '{16'h8000, 16'h8F00, 3'd0, 2'd3, 16'h8000, 16'h8000, 2'b11};
        tbl[10] = '{16'h1234, 16'h5678, 3'd5, 2'd0, 16'h0000, 16'h0000, 2'b00};
        tbl[11] = '{16'h7F00, 16'h7F00, 3'd7, 2'd2, 16'h0000, 16'h0000, 2'b00};
        tbl[12] = '{16'h7FFF, 16'h8001, 3'd3, 2'd0, 16'h7FFF, 16'h0000, 2'b00};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_mode   = '0;
        bus.in_slot   = '0;
        bus.out_ready = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_slot  = '0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.cfg_clr   = 1'b0;
        cur_exp.fx    = '0;
        cur_exp.sat   = '0;

        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_fx",    bus.out_fx,          32'd0);
        check("rst_out_sat",   32'(bus.out_sat),    32'd0);
        check("rst_sat_count", 32'(bus.sat_count),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);

        cfg_wr(2'd0, 4'd0,  16'h2000, 16'h0100);
        cfg_wr(2'd0, 4'd15, 16'h0800, 16'h0000);
        cfg_wr(2'd2, 4'd7,  16'h7FFF, 16'h0000);
        cfg_wr(2'd3, 4'd8,  16'h7FFF, 16'h0000);
        cfg_wr(2'd1, 4'd2,  16'h1000, 16'h0000);

        // Single beat into an idle pipe: out_valid on the third edge after acceptance.
        send(tbl[0]);
        idle();
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            if (bus.out_valid) lat = n;
        end
        check("latency", 32'(lat), 32'd3);
        tick(1);
        drain();

        for (int i = 0; i < 13; i++) send(tbl[i]);
        idle();
        drain();
        check("sat_count_table", 32'(bus.sat_count), 32'd2);

        // Clear alone, one saturated beat, then clear coinciding with a saturated transfer.
        bus.cfg_clr = 1'b1;
        tick(1);
        bus.cfg_clr = 1'b0;
        check("sat_count_clr", 32'(bus.sat_count), 32'd0);
        send(tbl[8]);
        idle();
        drain();
        check("sat_count_inc", 32'(bus.sat_count), 32'd1);
        send(tbl[8]);
        idle();
        tick(2);
        check("clr_xfer_valid", 32'(bus.out_valid), 32'd1);
        bus.cfg_clr = 1'b1;
        tick(1);
        bus.cfg_clr = 1'b0;
        check("sat_count_clr_wins", 32'(bus.sat_count), 32'd0);
        drain();

        // Output stalled for 6 cycles while five beats are offered.
        bus.out_ready = 1'b0;
        k = 0;
        set_beat(id_vec(0));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                if (k < 5) set_beat(id_vec(k));
            end
        end
        check("stall_accepted", 32'(k), 32'd3);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 5; c++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                if (k < 5) set_beat(id_vec(k));
            end
        end
        check("stall_all_accepted", 32'(k), 32'd5);
        idle();
        drain();

        // LUT write in the same cycle a beat reads that entry: old then new coefficients.
        bus.cfg_slot = 2'd1;
        bus.cfg_addr = 4'd2;
        bus.cfg_data = {16'h0800, 16'h0100};
        bus.cfg_we   = 1'b1;
        v = '{16'h2000, 16'h2100, 3'd0, 2'd1, 16'h2000, 16'h2100, 2'b00};
        send(v);
        bus.cfg_we = 1'b0;
        v = '{16'h2000, 16'h2100, 3'd0, 2'd1, 16'h1100, 16'h1180, 2'b00};
        send(v);
        idle();
        drain();

        // Reset with three beats in flight.
        send(tbl[8]);
        idle();
        drain();
        check("sat_count_pre_rst", 32'(bus.sat_count), 32'd1);
        for (int i = 0; i < 3; i++) send(id_vec(i + 6));
        idle();
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        sat_model = 16'd0;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_sat_count", 32'(bus.sat_count), 32'd0);
        check("async_rst_out_fx",    bus.out_fx,          32'd0);
        check("async_rst_out_sat",   32'(bus.out_sat),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(10);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        send(tbl[6]);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
